// File: rtl/vga_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vga_step_scheduler
// Purpose  : Plays a STEPS-entry pattern of four 4-bit step values into the
//            VGA bar renderer, advancing on vsync frame ticks.
//            Define VGA_STEP_DECAY_EN for per-frame falloff of the steps.
// Revision : 1.0
// ============================================================================
module vga_step_scheduler #(
    parameter int STEPS          = 16,
    parameter int TICKS_PER_STEP = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ena,
    input  logic        vsync,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [15:0] cfg_data,
    input  logic        start,
    input  logic        stop,
    output logic [3:0]  s1,
    output logic [3:0]  s2,
    output logic [3:0]  s3,
    output logic [3:0]  s4,
    output logic [5:0]  bar_counter,
    output logic        step_strobe,
    output logic        busy,
    output logic [1:0]  state
);

    localparam int                 c_IDX_W     = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(STEPS - 1);
    localparam logic [7:0]         c_LAST_TICK = 8'(TICKS_PER_STEP - 1);
    localparam logic [4:0]         c_STEPS_LIM = 5'(STEPS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_vsync_d;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_IDX_W-1:0]   w_idx_nxt;
    logic [c_IDX_W-1:0]   w_load_idx;
    logic [7:0]           r_cnt;
    logic [7:0]           w_cnt_nxt;
    logic [15:0]          r_step;
    logic [15:0]          w_step_nxt;
    logic [15:0]          w_decayed;
    logic [5:0]           r_bar;
    logic [5:0]           w_bar_nxt;
    logic                 r_strobe;
    logic                 w_load;
    logic                 w_tick;
    logic                 w_wr_en;
    logic [15:0]          r_mem [0:STEPS-1];

    assign w_tick  = ena & r_vsync_d & ~vsync;
    assign w_wr_en = ena & cfg_we & ({1'b0, cfg_addr} < c_STEPS_LIM);

`ifdef VGA_STEP_DECAY_EN
    // Meter-style falloff: each nibble drops by one per frame, floor at zero.
    for (genvar g = 0; g < 4; g++) begin : g_decay
        assign w_decayed[g*4 +: 4] = (r_step[g*4 +: 4] == 4'd0) ? 4'd0
                                                                 : r_step[g*4 +: 4] - 4'd1;
    end
`else
    assign w_decayed = r_step;
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else if (ena) begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_step_nxt  = r_step;
        w_bar_nxt   = r_bar;
        w_load      = 1'b0;
        w_load_idx  = r_idx;

        if (ena) begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        w_state_nxt = ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (stop) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_tick) begin
                        w_load      = 1'b1;
                        w_load_idx  = '0;
                        w_idx_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A stop discards any tick arriving in the same cycle.
                    if (stop) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (w_tick) begin
                        if (r_cnt == c_LAST_TICK) begin
                            w_cnt_nxt  = '0;
                            w_load     = 1'b1;
                            w_load_idx = r_idx + 1'b1;
                            w_idx_nxt  = w_load_idx;
                            if (r_idx == c_LAST_IDX) begin
                                w_bar_nxt = r_bar + 6'd1;
                            end
                        end else begin
                            w_cnt_nxt  = r_cnt + 8'd1;
                            w_step_nxt = w_decayed;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (stop) begin
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_step_nxt  = '0;
                        w_bar_nxt   = '0;
                    end else if (start) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        // Loads read the memory before any same-cycle write lands.
        if (w_load) begin
            w_step_nxt = r_mem[w_load_idx];
        end
    end

    // ------------------------------------------------------------------------
    // Playback datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vsync_d <= 1'b1;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_step    <= '0;
            r_bar     <= '0;
            r_strobe  <= 1'b0;
        end else begin
            // w_load is already qualified by ena, so the pulse never stretches.
            r_strobe <= w_load;
            if (ena) begin
                r_vsync_d <= vsync;
                r_idx     <= w_idx_nxt;
                r_cnt     <= w_cnt_nxt;
                r_step    <= w_step_nxt;
                r_bar     <= w_bar_nxt;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pattern memory
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STEPS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[cfg_addr[c_IDX_W-1:0]] <= cfg_data;
        end
    end

    assign s1          = r_step[15:12];
    assign s2          = r_step[11:8];
    assign s3          = r_step[7:4];
    assign s4          = r_step[3:0];
    assign bar_counter = r_bar;
    assign step_strobe = r_strobe & ena;
    assign busy        = (r_state != ST_IDLE);
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_vga_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_step_scheduler
// Purpose  : Directed and randomized bench for vga_step_scheduler with a
//            step-position reference model.
// Revision : 1.0
// ============================================================================
module tb_vga_step_scheduler;

    localparam int STEPS = 8;
    localparam int TPS   = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        ena;
    logic        vsync;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        start;
    logic        stop;
    logic [3:0]  s1, s2, s3, s4;
    logic [5:0]  bar_counter;
    logic        step_strobe;
    logic        busy;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;

    vga_step_scheduler #(
        .STEPS          (STEPS),
        .TICKS_PER_STEP (TPS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ena         (ena),
        .vsync       (vsync),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .start       (start),
        .stop        (stop),
        .s1          (s1),
        .s2          (s2),
        .s3          (s3),
        .s4          (s4),
        .bar_counter (bar_counter),
        .step_strobe (step_strobe),
        .busy        (busy),
        .state       (state)
    );

    always #5 clock = ~clock;

    // Reference model: playback tracked as an absolute step position; the
    // entry index and loop count are derived from it arithmetically.
    int          m_state;
    int          m_pos;
    int          m_cnt;
    logic [15:0] m_disp;
    logic [15:0] m_mem [STEPS];
    logic        m_vd;
    logic        m_strobe;
    logic        m_tk;
    bit          m_valid = 1'b0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_state  = 0;
            m_pos    = 0;
            m_cnt    = 0;
            m_disp   = '0;
            m_vd     = 1'b1;
            m_strobe = 1'b0;
            for (int k = 0; k < STEPS; k++) m_mem[k] = '0;
            m_valid  = 1'b1;
        end else begin
            m_strobe = 1'b0;
            if (ena) begin
                m_tk = m_vd && !vsync;
                case (m_state)
                    0: if (start && !stop) m_state = 1;
                    1: begin
                        if (stop) m_state = 0;
                        else if (m_tk) begin
                            m_pos = 0; m_cnt = 0; m_disp = m_mem[0];
                            m_strobe = 1'b1; m_state = 2;
                        end
                    end
                    2: begin
                        if (stop) m_state = 3;
                        else if (m_tk) begin
                            if (m_cnt + 1 == TPS) begin
                                m_cnt = 0; m_pos = m_pos + 1;
                                m_disp = m_mem[m_pos % STEPS];
                                m_strobe = 1'b1;
                            end else begin
                                m_cnt = m_cnt + 1;
`ifdef VGA_STEP_DECAY_EN
                                for (int k = 0; k < 4; k++)
                                    if (m_disp[k*4 +: 4] != 4'd0) m_disp[k*4 +: 4] = m_disp[k*4 +: 4] - 4'd1;
`endif
                            end
                        end
                    end
                    default: begin
                        if (stop) begin
                            m_state = 0; m_pos = 0; m_cnt = 0; m_disp = '0;
                        end else if (start) m_state = 2;
                    end
                endcase
                if (cfg_we && int'(cfg_addr) < STEPS) m_mem[int'(cfg_addr)] = cfg_data;
                m_vd = vsync;
            end
        end
    end

    logic [25:0] exp_v, got_v;

    always @(negedge clock) begin
        if (m_valid) begin
            exp_v = {2'(m_state), (m_state != 0), m_disp, 6'((m_pos / STEPS) % 64), m_strobe && ena};
            got_v = {state, busy, s1, s2, s3, s4, bar_counter, step_strobe};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL outputs t=%0t got=%h expected=%h (state,busy,s1..s4,bar,strobe)",
                         $time, got_v, exp_v);
            end
            if (step_strobe === 1'b1) strobe_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic vtick();
        vsync = 1'b0;
        @(posedge clock); #1;
        vsync = 1'b1;
        cycles($urandom_range(1, 3));
    endtask

    task automatic vticks(input int n);
        repeat (n) vtick();
    endtask

    task automatic pulse(input logic st, input logic sp);
        start = st; stop = sp;
        @(posedge clock); #1;
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic write(input logic [3:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clock); #1;
        cfg_we = 1'b0;
    endtask

    logic [15:0] pat [8] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                             16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978};

    initial begin
        reset = 1'b1; ena = 1'b1; vsync = 1'b1; cfg_we = 1'b0;
        cfg_addr = '0; cfg_data = '0; start = 1'b0; stop = 1'b0;
        cycles(3);
        reset = 1'b0;
        check("reset_outputs", 32'({state, busy, s1, s2, s3, s4, bar_counter, step_strobe}), 32'h0);

        vticks(10);
        check("idle_no_strobe", 32'(strobe_cnt), 32'd0);
        check("idle_state", 32'(state), 32'd0);

        for (int i = 0; i < 8; i++) write(4'(i), pat[i]);
        write(4'd15, 16'hFFFF);
        write(4'd8, 16'hEEEE);

        pulse(1'b1, 1'b0);
        check("arm_state", 32'({state, busy}), 32'b011);
        vtick();
        check("first_load", 32'({s1, s2, s3, s4}), 32'h1234);
        check("first_state", 32'(state), 32'd2);
        check("first_strobe", 32'(strobe_cnt), 32'd1);
        vticks(2);
        check("hold_no_strobe", 32'(strobe_cnt), 32'd1);
        vtick();
        check("second_load", 32'({s1, s2, s3, s4}), 32'h5678);

        vticks(1530);
        check("pre_wrap_bar", 32'(bar_counter), 32'd63);
        check("entry7_not_clobbered", 32'({s1, s2, s3, s4}), 32'h6978);
        check("pre_wrap_strobes", 32'(strobe_cnt), 32'd512);
        vticks(3);
        check("wrap_bar", 32'(bar_counter), 32'd0);
        check("wrap_load", 32'({s1, s2, s3, s4}), 32'h1234);
        check("wrap_strobes", 32'(strobe_cnt), 32'd513);

        pulse(1'b0, 1'b1);
        check("pause_state", 32'(state), 32'd3);
        vticks(5);
        check("pause_frozen", 32'({s1, s2, s3, s4}), 32'h1234);
        check("pause_no_strobe", 32'(strobe_cnt), 32'd513);
        pulse(1'b1, 1'b0);
        check("resume_state", 32'(state), 32'd2);
        vticks(2);
        check("resume_remaining", 32'(strobe_cnt), 32'd513);
        vtick();
        check("resume_advance", 32'({s1, s2, s3, s4}), 32'h5678);

        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        check("abort_outputs", 32'({state, busy, s1, s2, s3, s4, bar_counter}), 32'h0);
        pulse(1'b1, 1'b0);
        vtick();
        check("replay_entry0", 32'({s1, s2, s3, s4}), 32'h1234);
        check("replay_strobes", 32'(strobe_cnt), 32'd515);

        pulse(1'b1, 1'b1);
        check("start_stop_pause", 32'(state), 32'd3);
        pulse(1'b0, 1'b1);
        check("back_idle", 32'(state), 32'd0);

        pulse(1'b1, 1'b0);
        vtick();
        ena = 1'b0; vsync = 1'b0;
        cycles(2);
        vsync = 1'b1;
        cycles(1);
        ena = 1'b1;
        cycles(1);
        vticks(2);
        check("ena_gap_no_tick", 32'(strobe_cnt), 32'd516);
        vtick();
        check("ena_gap_advance", 32'({s1, s2, s3, s4}), 32'h5678);

        #2 reset = 1'b1;
        #1 check("async_reset", 32'({state, busy, s1, s2, s3, s4, bar_counter, step_strobe}), 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;

        for (int n = 0; n < 5000; n++) begin
            ena      = ($urandom_range(0, 9) != 0);
            vsync    = ($urandom_range(0, 3) != 0);
            cfg_we   = vsync && ($urandom_range(0, 3) == 0);
            cfg_addr = 4'($urandom_range(0, 15));
            cfg_data = 16'($urandom);
            start    = ($urandom_range(0, 6) == 0);
            stop     = ($urandom_range(0, 24) == 0);
            reset    = ($urandom_range(0, 999) == 0);
            @(posedge clock); #1;
        end
        reset = 1'b0; start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
        cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
